dmw_multi: RTL
==============

# dmw_multi

Parametrised bank of LoongArch Direct-Mapped Windows (DMW) combined with a one-stage registered address-translation pipeline. It holds `NUM_WIN` window CSRs written by the CSR unit and translates virtual addresses from the load/store front end under a valid/ready handshake. It reports hit, physical address, memory-access type and multi-hit status to the memory pipeline.

## Interface
- `NUM_WIN`, default 2: number of windows (1..8). Window 0 has the highest priority.
- `IDX_W`, default 3: width of the CSR window index ports.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `csr_wr_en` input 1: CSR write strobe.
- `csr_wr_idx` input IDX_W: window selected for the write.
- `csr_wr_data` input 32: write data.
- `csr_wr_mask` input 32: per-bit write mask. Present only with `DMW_XCHG_EN`.
- `csr_rd_idx` input IDX_W: window selected for the read.
- `csr_rd_data` output 32: combinational read of the selected window.
- `req_valid` input 1: a translation request is present.
- `req_ready` output 1: the block can accept a request.
- `req_va` input 32: virtual address.
- `req_plv` input 2: current privilege level.
- `resp_valid` output 1: a translation result is present.
- `resp_ready` input 1: the consumer accepts the result.
- `resp_hit` output 1: at least one window matched.
- `resp_multi` output 1: two or more windows matched.
- `resp_win` output IDX_W: index of the winning window.
- `resp_pa` output 32: physical address.
- `resp_mat` output 2: memory-access type of the winning window.

## Operation
- Writable field mask is `0xEE00_0039`: VSEG[31:29], PSEG[27:25], MAT[5:4], PLV3[3], PLV0[0]. All other bits are stored as 0 and read back as 0.
- Write rule: `win[idx] <= csr_wr_data & 32'hEE00_0039`. The write is ignored when `idx >= NUM_WIN`.
- A read with `csr_rd_idx >= NUM_WIN` returns 0.
- Window i hits when both conditions hold:
  - `req_va[31:29] == VSEG_i`;
  - either (`req_plv == 0` and PLV0_i) or (`req_plv == 3` and PLV3_i).
  - PLV 1 and 2 never hit.
- Winner is the lowest-index hitting window.
  - `resp_pa = {PSEG_win, req_va[28:0]}`.
  - `resp_mat = MAT_win`.
- On a miss: `resp_hit=0`, `resp_pa=req_va`, `resp_mat=0`, `resp_win=0`.
- `resp_multi` is set when two or more windows hit; the winner is still reported.
- Output register state machine:
  - States: EMPTY (`resp_valid=0`) and FULL (`resp_valid=1`).
  - EMPTY→FULL on `req_valid`.
  - FULL→FULL on `resp_ready && req_valid` (new result loaded).
  - FULL→EMPTY on `resp_ready && !req_valid`.
  - FULL holds on `!resp_ready`.
- `req_ready = !resp_valid || resp_ready`. It is combinational from `resp_ready` and has no path from `req_valid`.
- A captured result stays stable while `resp_valid && !resp_ready`. Later window writes do not alter it.

## Timing
- Reset values:
  - all windows 0;
  - `resp_valid=0`, `resp_hit=0`, `resp_multi=0`, `resp_win=0`, `resp_pa=0`, `resp_mat=0`;
  - `req_ready=1` immediately after reset.
- CSR write takes effect at the clock edge. `csr_rd_data` shows the new value in the following cycle, with no same-cycle bypass.
- Translation latency is 1 cycle: a request accepted at edge N produces its result on `resp_*` after edge N.
- Throughput is 1 request per cycle while `resp_ready=1`.
- A write and a lookup in the same cycle: the lookup uses the pre-write window values. A lookup in the next cycle sees the new value.
- Reset asserted mid-transaction clears the held result asynchronously. An in-flight request is dropped, not replayed.

## Configuration
- `DMW_XCHG_EN` defined:
  - the `csr_wr_mask` port exists;
  - write rule becomes `win <= (win & ~m) | (csr_wr_data & m)` with `m = csr_wr_mask & 32'hEE00_0039`. This supports `csrxchg`.
- `DMW_XCHG_EN` undefined:
  - the port is absent;
  - every write is a full masked overwrite, which supports `csrwr` only.

## Test plan
- Reset, then write `0xFFFF_FFFF` to window 0 and read it back → `0xEE00_0039`. Write to idx `NUM_WIN` → no state change, and the read of that idx returns 0.
- Window 0 = `0xA000_0011`, request va `0xA000_1234` with plv 0 → next cycle hit=1, pa=`0x0000_1234`, mat=1, win=0. The same va with plv 3 → hit=0, pa=`0xA000_1234`.
- Windows 0 and 1 both `0xA000_0019`, request va `0xA123_4567` with plv 3 → hit=1, multi=1, win=0.
- With `resp_ready` held low for 3 cycles after a result, plus a window-0 write during the stall → `resp_*` held constant and `req_ready=0`. Releasing `resp_ready` with `req_valid` high gives back-to-back results.
- Same-cycle write of window 0 = `0xC000_0001` and lookup of va `0xC000_0000` with plv 0 → miss, using the old value 0. A repeat lookup the next cycle → hit.
- With `DMW_XCHG_EN`: window = `0xA000_0011`, write data `0x20` with mask `0x30` → `0xA000_0021`. Assert reset while `resp_valid=1` → `resp_valid=0` and the window reads 0.

Source files
------------

// File: rtl/dmw_multi.sv
// dmw_multi: bank of LoongArch direct-mapped windows with a one-stage registered translation pipeline
// Ports: clk/rst_n (async active-low); csr_wr_en/idx/data (+csr_wr_mask when DMW_XCHG_EN is defined) write a window;
// csr_rd_idx/csr_rd_data read a window combinationally; req_valid/req_ready/req_va/req_plv take a lookup;
// resp_valid/resp_ready/resp_hit/resp_multi/resp_win/resp_pa/resp_mat return the registered result.
// Optional macro DMW_XCHG_EN: adds csr_wr_mask for masked (csrxchg) writes.
module dmw_multi #(
    parameter int NUM_WIN = 2,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_wr_en,
    input  logic [IDX_W-1:0] csr_wr_idx,
    input  logic [31:0]      csr_wr_data,
`ifdef DMW_XCHG_EN
    input  logic [31:0]      csr_wr_mask,
`endif
    input  logic [IDX_W-1:0] csr_rd_idx,
    output logic [31:0]      csr_rd_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_va,
    input  logic [1:0]       req_plv,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic             resp_multi,
    output logic [IDX_W-1:0] resp_win,
    output logic [31:0]      resp_pa,
    output logic [1:0]       resp_mat
);
    localparam logic [31:0] FIELDS = 32'hEE00_0039;
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [31:0] win [NUM_WIN];
    logic [31:0] wr_mask;
    logic [NUM_WIN-1:0] hit;
    logic any_hit, multi_hit, load;
    logic [IDX_W-1:0] sel_idx;
    logic [2:0] sel_pseg;
    logic [1:0] sel_mat;
`ifdef DMW_XCHG_EN
    assign wr_mask = csr_wr_mask & FIELDS;
`else
    assign wr_mask = FIELDS;
`endif
    // Unwritable bits are always 0 in storage, so the merge degenerates to a plain overwrite when the mask is FIELDS.
    // Indices >= NUM_WIN match no window and are dropped.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < NUM_WIN; i++) win[i] <= '0;
        else
            for (int i = 0; i < NUM_WIN; i++)
                if (csr_wr_en && csr_wr_idx == IDX_W'(i))
                    win[i] <= (win[i] & ~wr_mask) | (csr_wr_data & wr_mask);
    always_comb begin
        csr_rd_data = '0;
        for (int i = 0; i < NUM_WIN; i++)
            if (csr_rd_idx == IDX_W'(i)) csr_rd_data = win[i];
    end
    // Walk from the highest index down so the lowest-index hit is the one left selected.
    always_comb begin
        hit = '0;
        any_hit = 1'b0;
        multi_hit = 1'b0;
        sel_idx = '0;
        sel_pseg = '0;
        sel_mat = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            hit[i] = req_va[31:29] == win[i][31:29] &&
                     ((req_plv == 2'd0 && win[i][0]) || (req_plv == 2'd3 && win[i][3]));
            if (hit[i]) begin
                multi_hit = multi_hit | any_hit;
                any_hit = 1'b1;
                sel_idx = IDX_W'(i);
                sel_pseg = win[i][27:25];
                sel_mat = win[i][5:4];
            end
        end
    end
    assign load = req_valid && req_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            resp_hit <= 1'b0;
            resp_multi <= 1'b0;
            resp_win <= '0;
            resp_pa <= '0;
            resp_mat <= '0;
        end else if (load) begin
            resp_hit <= any_hit;
            resp_multi <= multi_hit;
            resp_win <= sel_idx;
            resp_pa <= any_hit ? {sel_pseg, req_va[28:0]} : req_va;
            resp_mat <= sel_mat;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;
    always_comb
        state_nx = (state == EMPTY || resp_ready) ? (req_valid ? FULL : EMPTY) : FULL;
    always_comb begin
        resp_valid = state == FULL;
        req_ready = !resp_valid || resp_ready;
    end
endmodule
